// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares the single port of a word-addressed instruction memory between the
// core fetch path (read) and a program loader (write). Byte addresses are
// turned into word indices. Misaligned or out-of-range accesses are granted
// and consumed but never reach the memory; they are answered with an error flag.
// Fetch wins conflicts, but a saturating starvation counter forces one loader
// grant after STARVE_LIMIT consecutive denials. Responses are registered and
// appear one cycle after the grant.

module imem_arbiter #(
  parameter int unsigned ADDR_INS_WIDTH = 32,
  parameter int unsigned MEMORY_WIDTH   = 32,
  parameter int unsigned MEMORY_HEIGHT  = 512,
  parameter int unsigned STARVE_LIMIT   = 4,
  localparam int unsigned IDX_W         = $clog2(MEMORY_HEIGHT),
  localparam int unsigned CNT_W         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,

  // Fetch requester (read-only)
  input  logic                      fetch_req,
  input  logic [ADDR_INS_WIDTH-1:0] fetch_addr,
  output logic                      fetch_gnt,
  output logic                      fetch_rvalid,
  output logic [MEMORY_WIDTH-1:0]   fetch_rdata,
  output logic                      fetch_err,

  // Loader requester (write-only)
  input  logic                      load_req,
  input  logic [ADDR_INS_WIDTH-1:0] load_addr,
  input  logic [MEMORY_WIDTH-1:0]   load_wdata,
  output logic                      load_gnt,
  output logic                      load_ack,
  output logic                      load_err,

  // Memory port
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [IDX_W-1:0]          mem_index,
  output logic [MEMORY_WIDTH-1:0]   mem_wdata,
  input  logic [MEMORY_WIDTH-1:0]   mem_rdata,

  // Debug: owner of the port in the previous cycle (0 idle, 1 fetch, 2 load)
  output logic [1:0]                owner_state
);

  // Returned in place of an instruction for a rejected fetch (addi x0,x0,0).
  localparam logic [MEMORY_WIDTH-1:0] NOP_INSN = MEMORY_WIDTH'(32'h0000_0013);
  localparam logic [CNT_W-1:0]        STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } owner_e;

  owner_e state_q, state_d;

  logic [CNT_W-1:0]        starve_q, starve_d;

  logic                    fetch_rvalid_q, fetch_rvalid_d;
  logic                    fetch_err_q, fetch_err_d;
  logic [MEMORY_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d;
  logic                    load_ack_q, load_ack_d;
  logic                    load_err_q, load_err_d;

  logic                    load_wins;
  logic                    fetch_inv, load_inv;
  logic [IDX_W-1:0]        fetch_idx, load_idx;

  // An address is unusable if it is not word aligned or lies past the last word.
  function automatic logic addr_invalid(input logic [ADDR_INS_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_INS_WIDTH-1:IDX_W+2] != '0);
  endfunction

  assign fetch_inv = addr_invalid(fetch_addr);
  assign load_inv  = addr_invalid(load_addr);
  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign load_idx  = load_addr[IDX_W+1:2];

  // Arbitration: fetch has priority unless the loader has waited the maximum.
  // Reset gates both grants so nothing is consumed or written while rst_n=0.
  always_comb begin
    load_wins = load_req && (!fetch_req || (starve_q == STARVE_MAX));
    load_gnt  = rst_n && load_wins;
    fetch_gnt = rst_n && fetch_req && !load_wins;
  end

  // Starvation counter: counts consecutive denied loader cycles, saturating.
  always_comb begin
    starve_d = '0;
    if (load_req && !load_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  // Owner FSM next state plus memory port drive. Idle and rejected accesses
  // leave the port disabled with index and data parked at zero.
  // NOTE: every output of this block gets a default first so that no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = IDLE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_index = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      state_d = FETCH;
      if (!fetch_inv) begin
        mem_en    = 1'b1;
        mem_index = fetch_idx;
      end
    end else if (load_gnt) begin
      state_d = LOAD;
      if (!load_inv) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_index = load_idx;
        mem_wdata = load_wdata;
      end
    end
  end

  // Response next-state: every grant produces exactly one response next cycle.
  // The instruction register keeps its last value when there is no fetch grant.
  always_comb begin
    fetch_rvalid_d = fetch_gnt;
    fetch_err_d    = fetch_gnt && fetch_inv;
    fetch_rdata_d  = fetch_rdata_q;
    if (fetch_gnt) begin
      fetch_rdata_d = fetch_inv ? NOP_INSN : mem_rdata;
    end
    load_ack_d = load_gnt;
    load_err_d = load_gnt && load_inv;
  end

  // Owner FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation counter and response registers; reset discards any response
  // pending from a grant in the cycle before reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q       <= '0;
      fetch_rvalid_q <= 1'b0;
      fetch_err_q    <= 1'b0;
      fetch_rdata_q  <= '0;
      load_ack_q     <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      starve_q       <= starve_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      fetch_err_q    <= fetch_err_d;
      fetch_rdata_q  <= fetch_rdata_d;
      load_ack_q     <= load_ack_d;
      load_err_q     <= load_err_d;
    end
  end

  assign fetch_rvalid = fetch_rvalid_q;
  assign fetch_err    = fetch_err_q;
  assign fetch_rdata  = fetch_rdata_q;
  assign load_ack     = load_ack_q;
  assign load_err     = load_err_q;
  assign owner_state  = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset values, single fetch, loader
// read-after-write, fetch/loader contention with starvation, address errors
// and the range boundary, and reset in the middle of a transaction.

module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;
  logic        load_gnt;
  logic        load_ack;
  logic        load_err;
  logic        mem_en;
  logic        mem_we;
  logic [8:0]  mem_index;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  owner_state;

  int checks = 0;
  int errors = 0;

  // Instruction memory model: word i preloaded with 0x0A000000+i, word 0
  // with a real instruction; writes on the rising edge, combinational read.
  logic [31:0] mem [0:511];
  logic        mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0A00_0000 + 32'(i);
      mem[0]    <= 32'h0041_82b3;
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_index] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_index];

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .load_req     (load_req),
    .load_addr    (load_addr),
    .load_wdata   (load_wdata),
    .load_gnt     (load_gnt),
    .load_ack     (load_ack),
    .load_err     (load_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_index    (mem_index),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .owner_state  (owner_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i set means the loader owns cycle i of the contention run.
  logic [9:0] exp_load = 10'b10_0001_0000;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset, with both requests pending ----------------
    rst_n      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    load_req   = 1'b1;
    load_addr  = 32'h40;
    load_wdata = 32'hDEAD_BEEF;
    #3;
    check1("rst_fetch_gnt", fetch_gnt, 1'b0);
    check1("rst_load_gnt", load_gnt, 1'b0);
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_rvalid", fetch_rvalid, 1'b0);
    check("rst_rdata", fetch_rdata, 32'h0);
    check1("rst_fetch_err", fetch_err, 1'b0);
    check1("rst_load_ack", load_ack, 1'b0);
    check1("rst_load_err", load_err, 1'b0);
    check("rst_owner", 32'(owner_state), 32'd0);
    tick();
    tick();
    tick();
    fetch_req = 1'b0;
    load_req  = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("rst_no_write", mem[16], 32'h0A00_0010);

    // ---------------- single fetch of word 0 ----------------
    fetch_req  = 1'b1;
    fetch_addr = 32'h000;
    #1;
    check1("f0_gnt", fetch_gnt, 1'b1);
    check1("f0_load_gnt", load_gnt, 1'b0);
    check1("f0_mem_en", mem_en, 1'b1);
    check1("f0_mem_we", mem_we, 1'b0);
    check("f0_index", 32'(mem_index), 32'd0);
    tick();
    fetch_req = 1'b0;
    #1;
    check1("f0_rvalid", fetch_rvalid, 1'b1);
    check("f0_rdata", fetch_rdata, 32'h0041_82b3);
    check1("f0_err", fetch_err, 1'b0);
    check("f0_owner", 32'(owner_state), 32'd1);
    check1("idle_gnt", fetch_gnt, 1'b0);
    check1("idle_mem_en", mem_en, 1'b0);
    check("idle_index", 32'(mem_index), 32'd0);
    tick();
    check1("idle_rvalid", fetch_rvalid, 1'b0);
    check("idle_rdata_hold", fetch_rdata, 32'h0041_82b3);
    check("idle_owner", 32'(owner_state), 32'd0);

    // ---------------- read after write ----------------
    load_req   = 1'b1;
    load_addr  = 32'h020;
    load_wdata = 32'h0010_8693;
    #1;
    check1("raw_load_gnt", load_gnt, 1'b1);
    check1("raw_fetch_gnt", fetch_gnt, 1'b0);
    check1("raw_mem_en", mem_en, 1'b1);
    check1("raw_mem_we", mem_we, 1'b1);
    check("raw_index", 32'(mem_index), 32'd8);
    check("raw_wdata", mem_wdata, 32'h0010_8693);
    tick();
    load_req   = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h020;
    #1;
    check1("raw_ack", load_ack, 1'b1);
    check1("raw_load_err", load_err, 1'b0);
    check("raw_owner", 32'(owner_state), 32'd2);
    check1("raw_f_gnt", fetch_gnt, 1'b1);
    check("raw_f_index", 32'(mem_index), 32'd8);
    tick();
    fetch_req = 1'b0;
    check1("raw_rvalid", fetch_rvalid, 1'b1);
    check("raw_rdata", fetch_rdata, 32'h0010_8693);
    check1("raw_ack_low", load_ack, 1'b0);
    tick();

    // ---------------- contention: F,F,F,F,L,F,F,F,F,L ----------------
    fetch_req  = 1'b1;
    fetch_addr = 32'h004;
    load_req   = 1'b1;
    load_addr  = 32'h100;
    load_wdata = 32'h1111_1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      check1($sformatf("arb%0d_fetch_gnt", i), fetch_gnt, !exp_load[i]);
      check1($sformatf("arb%0d_load_gnt", i), load_gnt, exp_load[i]);
      if (i > 0) begin
        check1($sformatf("arb%0d_ack", i), load_ack, exp_load[i-1]);
        check1($sformatf("arb%0d_rvalid", i), fetch_rvalid, !exp_load[i-1]);
        if (!exp_load[i-1]) check($sformatf("arb%0d_rdata", i), fetch_rdata, 32'h0A00_0001);
      end
      tick();
      if (exp_load[i]) begin
        load_addr  = 32'h104;
        load_wdata = 32'h2222_2222;
      end
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    check1("arb_last_ack", load_ack, 1'b1);
    check1("arb_last_rvalid", fetch_rvalid, 1'b0);
    check("arb_mem64", mem[64], 32'h1111_1111);
    check("arb_mem65", mem[65], 32'h2222_2222);
    tick();

    // ---------------- address errors and range boundary ----------------
    fetch_req  = 1'b1;
    fetch_addr = 32'h002;
    #1;
    check1("mis_gnt", fetch_gnt, 1'b1);
    check1("mis_mem_en", mem_en, 1'b0);
    tick();
    fetch_addr = 32'h800;
    check1("mis_rvalid", fetch_rvalid, 1'b1);
    check1("mis_err", fetch_err, 1'b1);
    check("mis_rdata", fetch_rdata, 32'h0000_0013);
    #1;
    check1("oor_gnt", fetch_gnt, 1'b1);
    check1("oor_mem_en", mem_en, 1'b0);
    tick();
    fetch_req  = 1'b0;
    load_req   = 1'b1;
    load_addr  = 32'h801;
    load_wdata = 32'hBAD0_BAD0;
    check1("oor_err", fetch_err, 1'b1);
    check("oor_rdata", fetch_rdata, 32'h0000_0013);
    #1;
    check1("lerr_gnt", load_gnt, 1'b1);
    check1("lerr_mem_en", mem_en, 1'b0);
    check1("lerr_mem_we", mem_we, 1'b0);
    tick();
    load_req   = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h7FC;
    check1("lerr_ack", load_ack, 1'b1);
    check1("lerr_err", load_err, 1'b1);
    check1("lerr_f_err_clr", fetch_err, 1'b0);
    check("lerr_mem0", mem[0], 32'h0041_82b3);
    #1;
    check1("top_mem_en", mem_en, 1'b1);
    check("top_index", 32'(mem_index), 32'd511);
    tick();
    fetch_req = 1'b0;
    check1("top_err", fetch_err, 1'b0);
    check("top_rdata", fetch_rdata, 32'h0A00_01FF);
    check1("top_load_ack_clr", load_ack, 1'b0);
    tick();

    // ---------------- reset in the middle of a transaction ----------------
    fetch_req  = 1'b1;
    fetch_addr = 32'h004;
    #1;
    check1("mid_gnt", fetch_gnt, 1'b1);
    tick();
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    load_req   = 1'b1;
    load_addr  = 32'h108;
    load_wdata = 32'h5555_5555;
    #1;
    check1("mid_rvalid", fetch_rvalid, 1'b0);
    check("mid_rdata", fetch_rdata, 32'h0);
    check1("mid_err", fetch_err, 1'b0);
    check("mid_owner", 32'(owner_state), 32'd0);
    check1("mid_load_gnt", load_gnt, 1'b0);
    check1("mid_mem_we", mem_we, 1'b0);
    tick();
    rst_n    = 1'b1;
    load_req = 1'b0;
    tick();
    check1("post_rvalid", fetch_rvalid, 1'b0);
    check1("post_ack", load_ack, 1'b0);
    check("post_mem66", mem[66], 32'h0A00_0042);
    fetch_req  = 1'b1;
    fetch_addr = 32'h008;
    #1;
    check1("post_gnt", fetch_gnt, 1'b1);
    tick();
    fetch_req = 1'b0;
    check1("post_f_rvalid", fetch_rvalid, 1'b1);
    check("post_f_rdata", fetch_rdata, 32'h0A00_0002);
    check1("post_f_err", fetch_err, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
